// File: rtl/incr_share_pkg.sv
// Shared definitions for the incrementer-sharing arbiter: datapath width,
// requester count, index width, the counter and index types, and a one-hot
// helper used to form the acknowledge vector.
package incr_share_pkg;
  localparam int W    = 8;
  localparam int NREQ = 4;
  localparam int IDW  = $clog2(NREQ);

  typedef logic [W-1:0]   cnt_t;
  typedef logic [IDW-1:0] id_t;

  function automatic logic [NREQ-1:0] onehot(id_t id);
    logic [NREQ-1:0] r;
    r     = '0;
    r[id] = 1'b1;
    return r;
  endfunction
endpackage

// File: rtl/incr_share_arbiter_rr_pick.sv
// Combinational round-robin priority picker.
// Ports:
//   elig  - per-requester eligibility vector
//   ptr   - index searched first; search wraps NREQ-1 -> 0
//   g     - selected requester index (0 when nothing is eligible)
//   valid - at least one requester is eligible
module rr_pick
  import incr_share_pkg::*;
(
  input  logic [NREQ-1:0] elig,
  input  logic [IDW-1:0]  ptr,
  output logic [IDW-1:0]  g,
  output logic            valid
);

  int idx;

  always_comb begin
    g     = '0;
    valid = 1'b0;
    idx   = 0;
    for (int k = 0; k < NREQ; k++) begin
      idx = (int'(ptr) + k) % NREQ;
      // First hit in rotated order wins; later hits are ignored.
      if (!valid && elig[idx]) begin
        valid = 1'b1;
        g     = id_t'(idx);
      end
    end
  end

endmodule

// File: rtl/incr_share_arbiter.sv
// Shares one W-bit wrap-around incrementer among NREQ requesters, each of
// which owns a private counter. A round-robin arbiter grants at most one
// requester per cycle; the granted counter advances by one and the result is
// returned on a registered acknowledge.
// Ports:
//   clk, rst  - clock, asynchronous active-high reset
//   en        - global enable; low freezes arbitration, counters and clears
//   req       - per-requester level request, held until ack
//   clr       - per-requester synchronous counter clear (needs en)
//   ack       - one-hot registered acknowledge pulse
//   ack_id    - index of the acknowledged requester
//   ack_val   - post-increment value of the acknowledged counter
//   ack_wrap  - the acknowledged increment wrapped all-ones -> 0
//   rd_id     - combinational read-port select
//   rd_val    - current value of the selected counter (0 if out of range)
module incr_share_arbiter
  import incr_share_pkg::*;
(
  input  logic            clk,
  input  logic            rst,
  input  logic            en,
  input  logic [NREQ-1:0] req,
  input  logic [NREQ-1:0] clr,
  output logic [NREQ-1:0] ack,
  output logic [IDW-1:0]  ack_id,
  output logic [W-1:0]    ack_val,
  output logic            ack_wrap,
  input  logic [IDW-1:0]  rd_id,
  output logic [W-1:0]    rd_val
);

  cnt_t            cnt [NREQ];
  id_t             ptr;
  id_t             g;
  id_t             ptr_nxt;
  logic            pick_vld;
  logic            gnt_vld;
  logic [NREQ-1:0] elig;
  logic [W:0]      sum;

  // Masking the requester currently being acknowledged makes a single
  // req-until-ack handshake produce exactly one increment.
  assign elig = req & ~ack;

  rr_pick u_pick (
    .elig  (elig),
    .ptr   (ptr),
    .g     (g),
    .valid (pick_vld)
  );

  assign gnt_vld = en & pick_vld;
  // Carry-out of the shared incrementer only feeds ack_wrap.
  assign sum     = {1'b0, cnt[g]} + (W+1)'(1);
  assign ptr_nxt = (g == id_t'(NREQ-1)) ? '0 : g + id_t'(1);

  // Stage p0 -> p1: counter bank update
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NREQ; i++) cnt[i] <= '0;
    end else if (en) begin
      for (int i = 0; i < NREQ; i++) begin
        // Clear takes priority over a coincident increment.
        if (clr[i])                            cnt[i] <= '0;
        else if (gnt_vld && g == id_t'(i))     cnt[i] <= sum[W-1:0];
      end
    end
  end

  // Stage p0 -> p1: acknowledge registers and round-robin pointer
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ack      <= '0;
      ack_id   <= '0;
      ack_val  <= '0;
      ack_wrap <= 1'b0;
      ptr      <= '0;
    end else if (gnt_vld) begin
      ack      <= onehot(g);
      ack_id   <= g;
      ack_val  <= clr[g] ? '0 : sum[W-1:0];
      ack_wrap <= sum[W] & ~clr[g];
      ptr      <= ptr_nxt;
    end else begin
      ack      <= '0;
      ack_wrap <= 1'b0;
    end
  end

  generate
    if (NREQ == (1 << IDW)) begin : g_rd_full
      assign rd_val = cnt[rd_id];
    end else begin : g_rd_part
      assign rd_val = (int'(rd_id) < NREQ) ? cnt[rd_id] : '0;
    end
  endgenerate

endmodule

// File: tb/tb_incr_share_arbiter.sv
module tb_incr_share_arbiter;
  import incr_share_pkg::*;

  logic            clk = 1'b0;
  logic            rst;
  logic            en;
  logic [NREQ-1:0] req;
  logic [NREQ-1:0] clr;
  logic [NREQ-1:0] ack;
  logic [IDW-1:0]  ack_id;
  logic [W-1:0]    ack_val;
  logic            ack_wrap;
  logic [IDW-1:0]  rd_id;
  logic [W-1:0]    rd_val;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    logic [NREQ-1:0] ack;
    logic [IDW-1:0]  id;
    logic [W-1:0]    val;
    logic            wrap;
  } exp_t;

  exp_t sb_q[$];

  // Reference model state
  logic [W-1:0]    mcnt [NREQ];
  int              mptr;
  logic [NREQ-1:0] mack;
  logic [IDW-1:0]  mack_id;
  logic [W-1:0]    mack_val;

  incr_share_arbiter dut (
    .clk      (clk),
    .rst      (rst),
    .en       (en),
    .req      (req),
    .clr      (clr),
    .ack      (ack),
    .ack_id   (ack_id),
    .ack_val  (ack_val),
    .ack_wrap (ack_wrap),
    .rd_id    (rd_id),
    .rd_val   (rd_val)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    checks++;
    if (obs !== exp_v) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp_v);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < NREQ; i++) mcnt[i] = '0;
    mptr     = 0;
    mack     = '0;
    mack_id  = '0;
    mack_val = '0;
    sb_q.delete();
  endtask

  // Predict the registered outputs produced by the next clock edge.
  task automatic model_step(output exp_t e);
    logic [NREQ-1:0] el;
    bit              found;
    int              gi;
    el    = req & ~mack;
    found = 1'b0;
    gi    = 0;
    for (int k = 0; k < NREQ; k++) begin
      int idx;
      idx = (mptr + k) % NREQ;
      if (!found && el[idx]) begin
        found = 1'b1;
        gi    = idx;
      end
    end
    if (en && found) begin
      e.ack  = '0;
      e.ack[gi] = 1'b1;
      e.id   = IDW'(gi);
      e.val  = clr[gi] ? '0 : mcnt[gi] + 1'b1;
      e.wrap = !clr[gi] && (mcnt[gi] == '1);
      mptr   = (gi + 1) % NREQ;
    end else begin
      e.ack  = '0;
      e.id   = mack_id;
      e.val  = mack_val;
      e.wrap = 1'b0;
    end
    if (en) begin
      for (int i = 0; i < NREQ; i++) begin
        if (clr[i])                mcnt[i] = '0;
        else if (found && i == gi) mcnt[i] = mcnt[i] + 1'b1;
      end
    end
    mack     = e.ack;
    mack_id  = e.id;
    mack_val = e.val;
  endtask

  // One clock: push prediction, clock, pop and compare.
  task automatic cyc();
    exp_t e;
    exp_t o;
    model_step(e);
    sb_q.push_back(e);
    @(posedge clk);
    #1;
    o = sb_q.pop_front();
    chk("sb_ack",  32'(ack),      32'(o.ack));
    chk("sb_id",   32'(ack_id),   32'(o.id));
    chk("sb_val",  32'(ack_val),  32'(o.val));
    chk("sb_wrap", 32'(ack_wrap), 32'(o.wrap));
    chk("sb_rd",   32'(rd_val),   32'(mcnt[rd_id]));
  endtask

  task automatic handshake(input int id);
    req[id] = 1'b1;
    cyc();
    req[id] = 1'b0;
    cyc();
  endtask

  initial begin
    int exp_ids[8] = '{0, 1, 2, 3, 0, 1, 2, 3};
    logic [IDW-1:0] prev_id;

    rst = 1'b1; en = 1'b0; req = '0; clr = '0; rd_id = '0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    chk("rst_ack",  32'(ack),      0);
    chk("rst_id",   32'(ack_id),   0);
    chk("rst_val",  32'(ack_val),  0);
    chk("rst_wrap", 32'(ack_wrap), 0);
    for (int i = 0; i < NREQ; i++) begin
      rd_id = IDW'(i);
      #1 chk("rst_rd", 32'(rd_val), 0);
    end
    @(negedge clk);
    rst = 1'b0;
    en  = 1'b1;

    // Single requester, two handshakes
    req = 4'b0010;
    cyc();
    chk("single_ack1", 32'(ack), 32'h2);
    chk("single_id1",  32'(ack_id), 1);
    chk("single_val1", 32'(ack_val), 1);
    req = '0;
    cyc();
    req = 4'b0010;
    cyc();
    chk("single_val2", 32'(ack_val), 2);
    req = '0;
    cyc();
    for (int i = 0; i < NREQ; i++) begin
      rd_id = IDW'(i);
      #1 chk("single_rd", 32'(rd_val), (i == 1) ? 2 : 0);
    end

    // Asynchronous reset while ack is high
    req = 4'b1000;
    cyc();
    chk("pre_rst_ack", 32'(ack), 32'h8);
    #3 rst = 1'b1;
    #1 chk("async_rst_ack", 32'(ack), 0);
    model_reset();
    for (int i = 0; i < NREQ; i++) begin
      rd_id = IDW'(i);
      #1 chk("async_rst_rd", 32'(rd_val), 0);
    end
    @(negedge clk);
    rst = 1'b0;
    cyc();
    chk("post_rst_id",  32'(ack_id), 3);
    chk("post_rst_val", 32'(ack_val), 1);
    req = '0;
    cyc();
    clr = 4'b1000;
    cyc();
    chk("clr_no_ack", 32'(ack), 0);
    clr = '0;

    // Fairness with all requesters held
    req = 4'b1111;
    prev_id = '0;
    for (int k = 0; k < 8; k++) begin
      cyc();
      chk("fair_id", 32'(ack_id), 32'(exp_ids[k]));
      if (k > 0) chk("fair_norepeat", 32'(ack_id != prev_id), 1);
      prev_id = ack_id;
    end
    req = '0;
    cyc();
    for (int i = 0; i < NREQ; i++) begin
      rd_id = IDW'(i);
      #1 chk("fair_rd", 32'(rd_val), 2);
    end

    // Wrap on requester 2
    clr = 4'b0100;
    cyc();
    clr = '0;
    rd_id = 2'd2;
    for (int n = 1; n <= 256; n++) begin
      req[2] = 1'b1;
      cyc();
      if (n == 255) begin
        chk("wrap_last_val",  32'(ack_val), 255);
        chk("wrap_last_flag", 32'(ack_wrap), 0);
      end
      if (n == 256) begin
        chk("wrap_val",  32'(ack_val), 0);
        chk("wrap_flag", 32'(ack_wrap), 1);
      end
      req[2] = 1'b0;
      cyc();
    end
    #1 chk("wrap_rd", 32'(rd_val), 0);

    // Clear colliding with grant
    clr = 4'b1000;
    cyc();
    clr = '0;
    for (int n = 0; n < 5; n++) handshake(3);
    rd_id = 2'd3;
    #1 chk("coll_pre_rd", 32'(rd_val), 5);
    req = 4'b1000;
    clr = 4'b1000;
    cyc();
    chk("coll_id",   32'(ack_id), 3);
    chk("coll_val",  32'(ack_val), 0);
    chk("coll_wrap", 32'(ack_wrap), 0);
    req = 4'b1001;
    clr = '0;
    cyc();
    chk("coll_next_id", 32'(ack_id), 0);
    cyc();
    req = '0;
    cyc();
    cyc();

    // Enable gating
    en  = 1'b0;
    req = 4'b0110;
    clr = 4'b0010;
    rd_id = 2'd1;
    for (int n = 0; n < 3; n++) begin
      cyc();
      chk("en_off_ack", 32'(ack), 0);
      chk("en_off_cnt1", 32'(rd_val), 2);
    end
    en  = 1'b1;
    clr = '0;
    cyc();
    chk("en_on_id",  32'(ack_id), 1);
    chk("en_on_val", 32'(ack_val), 3);
    cyc();
    chk("en_on_id2", 32'(ack_id), 2);
    req = '0;
    cyc();

    // Randomized traffic against the scoreboard
    for (int n = 0; n < 400; n++) begin
      req   = NREQ'($urandom);
      clr   = ($urandom_range(0, 7) == 0) ? NREQ'($urandom) : '0;
      en    = ($urandom_range(0, 9) != 0);
      rd_id = IDW'($urandom);
      cyc();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

endmodule

// File: doc/incr_share_arbiter.md
Name: incr_share_arbiter

Overview:
- Shares one W-bit wrap-around incrementer datapath among NREQ requesters.
- Each requester owns a private counter in a register bank.
- A round-robin arbiter grants at most one requester per cycle. The granted counter advances by 1, and the result is returned on a registered acknowledge.
- Sits between the requester-side control logic and the shared incrementer; it is the only block that sequences that datapath.

Parameters:
- W, 8, counter/datapath width in bits.
- NREQ, 4, number of requesters (2..16).
- IDW, $clog2(NREQ), requester index width.

Ports:
- clk  input  1  clock.
- rst  input  1  reset, asynchronous, active-high.
- en  input  1  global enable; 0 freezes arbitration and all counters.
- req  input  NREQ  per-requester increment request, level, held until ack.
- clr  input  NREQ  per-requester synchronous counter clear.
- ack  output  NREQ  one-hot registered grant acknowledge, single-cycle pulse.
- ack_id  output  IDW  index of the acknowledged requester.
- ack_val  output  W  post-increment counter value of the acknowledged requester.
- ack_wrap  output  1  high with ack when that increment wrapped 2^W-1 -> 0.
- rd_id  input  IDW  combinational read-port select.
- rd_val  output  W  current value of cnt[rd_id] (combinational).

Behaviour:
- Reset (async, any time, including mid-grant):
  - cnt[*]=0, ack=0, ack_id=0, ack_val=0, ack_wrap=0, ptr=0.
  - rd_val tracks cnt, so it reads 0.
  - The first grant after reset release searches from requester 0.
- Eligible set: elig = req & ~ack. A requester whose ack is high this cycle is masked, so one req-until-ack handshake yields exactly one increment when the requester drops req the cycle after seeing ack.
- Grant, combinational: g = first index i in ptr, ptr+1, ..., NREQ-1, 0, ..., ptr-1 with elig[i]=1. The grant is valid iff en=1 and |elig.
- On a clock edge with a valid grant:
  - cnt[g] <= cnt[g]+1 mod 2^W.
  - ack <= onehot(g), ack_id <= g, ack_val <= cnt[g]+1 mod 2^W.
  - ack_wrap <= (cnt[g]==2^W-1).
  - ptr <= (g+1) mod NREQ.
- On a clock edge with no valid grant:
  - ack <= 0, ack_wrap <= 0.
  - ack_id, ack_val and ptr hold; counters unchanged except clr.
- Latency: request to ack is 1 cycle.
- Throughput: 1 increment per cycle aggregate; 1 per 2 cycles for a single requester.
- clr[i], applied when en=1:
  - Sets cnt[i] <= 0 and does not generate ack by itself.
  - If clr[g] coincides with the grant to g: clear wins, cnt[g] <= 0, and ack is still issued with ack_val=0 and ack_wrap=0. ptr advances normally.
- en=0: no grants, clr ignored, ack deasserts next edge, ptr holds.
- Width rule: all arithmetic is W bits unsigned; the carry-out is used only for ack_wrap.
- rd_id >= NREQ: rd_val=0.

Decomposition:
- Package incr_share_pkg holds:
  - W, NREQ, IDW;
  - typedef cnt_t (logic [W-1:0]);
  - typedef id_t (logic [IDW-1:0]);
  - function onehot(id_t).
- Sub-module rr_pick: combinational round-robin priority picker.
  - Inputs: elig[NREQ], ptr.
  - Outputs: g, valid.
- The top-level holds ptr, the counter bank, the incrementer and the ack registers.

Test Plan:
- Reset/readback: assert rst mid-cycle while ack=1 -> ack=0 immediately; rd_val=0 for ids 0..3; after release with req=4'b1000 the grant goes to 3 and ack_val=1.
- Single requester: req[1] for 1 cycle, twice, en=1 -> ack=4'b0010, ack_id=1, ack_val=1, then ack_val=2; other counters stay 0.
- Fairness: req=4'b1111 held continuously, en=1, ptr=0 -> ack_id sequence 0,1,2,3,0,1 on consecutive cycles. Each counter reaches 2 after 8 acks; no requester is acknowledged twice in a row.
- Wrap: 255 handshakes on req[2] -> last ack_val=255 with ack_wrap=0; next ack_val=0 with ack_wrap=1; rd_id=2 then reads 0.
- Clear collision: cnt[3]=5, req[3] and clr[3] in the same cycle -> ack_id=3, ack_val=0, ack_wrap=0; next grant with req=4'b1001 goes to 0 (ptr wrapped).
- Enable gating: en=0 with req=4'b0110 and clr=4'b0010 for 3 cycles -> ack=0 and counters unchanged; on en=1 requester 1 is granted first from ptr=0.
